// File: rtl/spi_slave_receiver.sv
// rtl/spi_slave_receiver.sv - SPI mode-0 responder, oversampled on the local clock
// Receives MSB-first words on MOSI and returns tx_data words on MISO.
module spi_slave_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_taken,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [2:0]    SETTLE   = 3'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_hist;
  logic                   r_cs_hist;
  logic [2:0]             r_settle;

  state_t                 r_state;
  logic [CW-1:0]          r_bit_cnt;
  logic                   r_word_end;
  logic [DATA_WIDTH-1:0]  r_rx_shift;
  logic [DATA_WIDTH-1:0]  r_tx_shift;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_valid;
  logic                   r_tx_taken;
  logic                   r_frame_error;
  logic                   r_miso_oe;
  logic                   r_busy;

  logic w_sclk;
  logic w_cs;
  logic w_mosi;
  logic w_armed;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
      r_settle    <= 3'd0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_hist <= w_sclk;
      r_cs_hist   <= w_cs;
      if (r_settle != SETTLE) r_settle <= r_settle + 3'd1;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // The CS synchronizer resets to "deselected"; until the real pin level has
  // reached the history flop, a low CS would look like a fresh falling edge.
  assign w_armed     = (r_settle == SETTLE);
  assign w_sclk_rise = w_sclk & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk & r_sclk_hist;
  assign w_cs_rise   = w_cs & ~r_cs_hist;
  assign w_cs_fall   = ~w_cs & r_cs_hist & w_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_word_end    <= 1'b0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_taken    <= 1'b0;
      r_frame_error <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_taken    <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_tx_shift <= tx_data;
            r_tx_taken <= 1'b1;
            r_bit_cnt  <= '0;
            r_word_end <= 1'b0;
            r_rx_shift <= '0;
            r_miso_oe  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            // Any SCLK edge in the same cycle is dropped; a partial word is discarded.
            r_frame_error <= (r_bit_cnt != '0);
            r_bit_cnt     <= '0;
            r_word_end    <= 1'b0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_miso_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
            if (r_bit_cnt == LAST_BIT) begin
              r_rx_data  <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              r_word_end <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_word_end) begin
              r_tx_shift <= tx_data;
              r_tx_taken <= 1'b1;
              r_word_end <= 1'b0;
            end else begin
              r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          r_bit_cnt  <= '0;
          r_word_end <= 1'b0;
          r_rx_shift <= '0;
          r_tx_shift <= '0;
          r_miso_oe  <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign MISO        = r_tx_shift[DATA_WIDTH-1];
  assign miso_oe     = r_miso_oe;
  assign tx_taken    = r_tx_taken;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb/tb_spi_slave_receiver.sv - directed bench for spi_slave_receiver
// Acts as a mode-0 master; drives on clk falling edges, observes on falling edges.
module tb_spi_slave_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_taken;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int tx_cnt  = 0;
  int fe_cnt  = 0;
  logic [7:0] rx_log [0:31];

  always #5 clk = ~clk;

  spi_slave_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_taken(tx_taken),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_cnt < 32) rx_log[rx_cnt] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_taken) tx_cnt = tx_cnt + 1;
    if (frame_error) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts nbits of mo MSB first; with last set, SCLK falls and CS rises together.
  task automatic xfer(input logic [7:0] mo, input int ph, input int nbits,
                      input bit last, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      MOSI = mo[i];
      wait_clk(ph);
      mi[i] = MISO;
      SCLK = 1'b1;
      wait_clk(ph);
      SCLK = 1'b0;
      if (last && i == 8 - nbits) CS = 1'b1;
    end
  endtask

  logic [7:0] got_a;
  logic [7:0] got_b;
  int rx_base;
  int tx_base;
  int fe_base;

  initial begin
    rst = 1'b0; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0; tx_data = 8'h00;
    wait_clk(2);
    check("rst_miso",     32'(MISO), 32'h0);
    check("rst_miso_oe",  32'(miso_oe), 32'h0);
    check("rst_rx_data",  32'(rx_data), 32'h0);
    check("rst_pulses",   32'({rx_valid, tx_taken, frame_error}), 32'h0);
    check("rst_busy",     32'(busy), 32'h0);
    rst = 1'b1;
    wait_clk(8);

    // Single word
    rx_base = rx_cnt; tx_base = tx_cnt; fe_base = fe_cnt;
    tx_data = 8'h3C;
    CS = 1'b0;
    xfer(8'hA5, 4, 8, 1'b1, got_a);
    wait_clk(6);
    check("single_rx_cnt",   32'(rx_cnt - rx_base), 32'd1);
    check("single_rx_data",  32'(rx_data), 32'hA5);
    check("single_miso",     32'(got_a), 32'h3C);
    check("single_tx_taken", 32'(tx_cnt - tx_base), 32'd1);
    check("single_no_fe",    32'(fe_cnt - fe_base), 32'd0);
    check("single_oe_off",   32'(miso_oe), 32'h0);

    // Back-to-back words in one CS assertion
    rx_base = rx_cnt; tx_base = tx_cnt; fe_base = fe_cnt;
    tx_data = 8'h96;
    CS = 1'b0;
    wait_clk(4);
    check("b2b_taken_first", 32'(tx_cnt - tx_base), 32'd1);
    check("b2b_oe_on",       32'(miso_oe), 32'h1);
    check("b2b_busy",        32'(busy), 32'h1);
    tx_data = 8'hC3;
    xfer(8'h12, 4, 8, 1'b0, got_a);
    xfer(8'h34, 4, 8, 1'b1, got_b);
    wait_clk(6);
    check("b2b_rx_cnt",   32'(rx_cnt - rx_base), 32'd2);
    check("b2b_rx_word0", 32'(rx_log[rx_base]), 32'h12);
    check("b2b_rx_word1", 32'(rx_log[rx_base + 1]), 32'h34);
    check("b2b_miso0",    32'(got_a), 32'h96);
    check("b2b_miso1",    32'(got_b), 32'hC3);
    check("b2b_tx_taken", 32'(tx_cnt - tx_base), 32'd2);
    check("b2b_no_fe",    32'(fe_cnt - fe_base), 32'd0);

    // Abort after five SCLK rises
    rx_base = rx_cnt; fe_base = fe_cnt;
    CS = 1'b0;
    xfer(8'hF0, 4, 5, 1'b0, got_a);
    check("abort_busy_mid", 32'(busy), 32'h1);
    CS = 1'b1;
    wait_clk(6);
    check("abort_fe",      32'(fe_cnt - fe_base), 32'd1);
    check("abort_no_rx",   32'(rx_cnt - rx_base), 32'd0);
    check("abort_rx_keep", 32'(rx_data), 32'h34);
    check("abort_oe",      32'(miso_oe), 32'h0);
    check("abort_busy",    32'(busy), 32'h0);
    check("abort_miso",    32'(MISO), 32'h0);

    // Reset in the middle of a frame, released with CS still low
    tx_data = 8'hFF;
    CS = 1'b0;
    xfer(8'hAA, 4, 3, 1'b0, got_a);
    rst = 1'b0;
    wait_clk(2);
    check("mrst_miso",    32'(MISO), 32'h0);
    check("mrst_oe",      32'(miso_oe), 32'h0);
    check("mrst_rx_data", 32'(rx_data), 32'h0);
    check("mrst_pulses",  32'({rx_valid, tx_taken, frame_error}), 32'h0);
    check("mrst_busy",    32'(busy), 32'h0);
    tx_base = tx_cnt; rx_base = rx_cnt;
    rst = 1'b1;
    wait_clk(10);
    check("mrst_no_start_busy",  32'(busy), 32'h0);
    check("mrst_no_start_taken", 32'(tx_cnt - tx_base), 32'd0);
    CS = 1'b1;
    wait_clk(6);
    tx_data = 8'h0F;
    CS = 1'b0;
    xfer(8'hFF, 4, 8, 1'b1, got_a);
    wait_clk(6);
    check("mrst_rx_data_ff", 32'(rx_data), 32'hFF);
    check("mrst_rx_cnt",     32'(rx_cnt - rx_base), 32'd1);
    check("mrst_miso",       32'(got_a), 32'h0F);

    // Minimum SCLK phase of SYNC_STAGES+1 clocks
    rx_base = rx_cnt;
    tx_data = 8'h5A;
    CS = 1'b0;
    xfer(8'h81, 3, 8, 1'b1, got_a);
    wait_clk(6);
    check("minph_rx_data", 32'(rx_data), 32'h81);
    check("minph_rx_cnt",  32'(rx_cnt - rx_base), 32'd1);
    check("minph_miso",    32'(got_a), 32'h5A);

    // SCLK toggling while deselected
    rx_base = rx_cnt; tx_base = tx_cnt;
    CS = 1'b1;
    tx_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      MOSI = i[0];
      SCLK = 1'b1;
      wait_clk(3);
      SCLK = 1'b0;
      wait_clk(3);
    end
    check("idle_miso",  32'(MISO), 32'h0);
    check("idle_oe",    32'(miso_oe), 32'h0);
    check("idle_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    check("idle_no_tx", 32'(tx_cnt - tx_base), 32'd0);
    check("idle_busy",  32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
